// File: rtl/scanner_link_pkg.sv
// Shared definitions for the inter-board scanner command link (rx and future tx).
package scanner_link_pkg;

    // Command encodings carried in the two data bits of a frame
    typedef enum logic [1:0] {
        COMM_INACTIVE      = 2'b00,
        COMM_GO_TO_STANDBY = 2'b01,
        COMM_START_SCAN    = 2'b10,
        COMM_START_FLUSH   = 2'b11
    } comm_e;

    // Frame layout: start(0), data LSB first, odd parity, stop(1)
    localparam int unsigned FRAME_DATA_BITS = 2;
    localparam logic        PARITY_ODD      = 1'b1;

    // Receiver state encoding
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    // True when data plus parity bit satisfy the link parity rule
    function automatic logic parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                       input logic                       par);
        return (^{data, par}) == PARITY_ODD;
    endfunction

endpackage

// File: rtl/link_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
module link_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Resynchronize into clk; both stages reset to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/scanner_link_rx.sv
// Receive end of the scanner command link: deserializes one framed 2-bit command,
// pulses comm_valid on a good frame, and flags/counts parity and framing errors.
module scanner_link_rx
    import scanner_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned ERR_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    output logic [1:0]       receive_comm,
    output logic             comm_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic             rx_busy
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (FRAME_DATA_BITS > 1) ? $clog2(FRAME_DATA_BITS) : 1;

    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_DATA_BITS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    logic rx_s;

    rx_state_e                  state_q, state_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       par_q, par_d;
    logic [1:0]                 comm_q, comm_d;
    logic                       valid_q, valid_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic [ERR_W-1:0]           err_q, err_d;
    logic                       busy_q, busy_d;

    logic timer_zero_c;
    logic par_good_c;
    logic bad_frame_c;

    link_sync2 u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (serial_in),
        .q_o   (rx_s)
    );

    assign timer_zero_c = (timer_q == '0);
    assign par_good_c   = parity_ok(shift_q, par_q);

    // Frame state machine: bit timing, shifting, stop-bit decision and error counting
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        comm_d      = 2'b00;
        valid_d     = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        bad_frame_c = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    timer_d = HALF_LOAD;
                end
            end
            RX_START: begin
                if (timer_zero_c) begin
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        timer_d = FULL_LOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            RX_DATA: begin
                if (timer_zero_c) begin
                    shift_d = {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
                    timer_d = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = RX_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            RX_PARITY: begin
                if (timer_zero_c) begin
                    par_d   = rx_s;
                    timer_d = FULL_LOAD;
                    state_d = RX_STOP;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            RX_STOP: begin
                if (timer_zero_c) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                        if (par_good_c) begin
                            valid_d = 1'b1;
                            comm_d  = shift_q;
                        end else begin
                            perr_d      = 1'b1;
                            bad_frame_c = 1'b1;
                        end
                    end else begin
                        // Line still low at stop: framing error, wait out any break
                        state_d     = RX_WAIT_HIGH;
                        ferr_d      = 1'b1;
                        perr_d      = !par_good_c;
                        bad_frame_c = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        err_d  = (bad_frame_c && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;
        busy_d = (state_d != RX_IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= {FRAME_DATA_BITS{1'b1}};
            par_q   <= 1'b0;
            comm_q  <= 2'b00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            comm_q  <= comm_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign receive_comm = comm_q;
    assign comm_valid   = valid_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign err_count    = err_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_scanner_link_rx.sv
// Directed bench for scanner_link_rx at CLKS_PER_BIT=8.
module tb_scanner_link_rx;

    localparam int unsigned CPB   = 8;
    localparam int unsigned ERR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             serial_in;
    logic [1:0]       receive_comm;
    logic             comm_valid;
    logic             parity_err;
    logic             frame_err;
    logic [ERR_W-1:0] err_count;
    logic             rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitor state
    int         cv_cnt = 0;
    int         pe_cnt = 0;
    int         fe_cnt = 0;
    int         stray  = 0;
    int         wide   = 0;
    logic       prev_cv = 1'b0;
    logic       prev_pe = 1'b0;
    logic       prev_fe = 1'b0;
    logic [1:0] comm_q[$];

    scanner_link_rx #(
        .CLKS_PER_BIT (CPB),
        .ERR_W        (ERR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .receive_comm (receive_comm),
        .comm_valid   (comm_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .err_count    (err_count),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Record pulses, captured commands, stray receive_comm values and over-wide pulses
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (comm_valid === 1'b1) begin
                cv_cnt++;
                comm_q.push_back(receive_comm);
            end else if (receive_comm !== 2'b00) begin
                stray++;
            end
            if (parity_err === 1'b1) pe_cnt++;
            if (frame_err === 1'b1) fe_cnt++;
            if ((comm_valid && prev_cv) || (parity_err && prev_pe) || (frame_err && prev_fe))
                wide++;
            prev_cv = comm_valid;
            prev_pe = parity_err;
            prev_fe = frame_err;
        end else begin
            prev_cv = 1'b0;
            prev_pe = 1'b0;
            prev_fe = 1'b0;
        end
    end

    task automatic clr_mon();
        cv_cnt = 0;
        pe_cnt = 0;
        fe_cnt = 0;
        comm_q.delete();
    endtask

    task automatic pop_comm(output logic [1:0] c);
        if (comm_q.size() > 0) c = comm_q.pop_front();
        else                   c = 2'bxx;
    endtask

    task automatic bit_tx(input logic v);
        serial_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic d0, input logic d1, input logic p, input logic stp);
        bit_tx(1'b0);
        bit_tx(d0);
        bit_tx(d1);
        bit_tx(p);
        bit_tx(stp);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    logic [1:0] c;

    initial begin
        reset     = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", comm_valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_comm", receive_comm, 2'b00);
        check("rst_err", err_count, 4'd0);
        check("rst_busy", rx_busy, 1'b0);
        reset = 1'b1;
        idle(5);

        // 1: good frame for START_SCAN
        clr_mon();
        send_frame(1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("t1_cv_cnt", cv_cnt, 1);
        pop_comm(c);
        check("t1_comm", c, 2'b10);
        check("t1_perr", pe_cnt, 0);
        check("t1_ferr", fe_cnt, 0);
        check("t1_err", err_count, 4'd0);
        check("t1_busy", rx_busy, 1'b0);

        // 2: bad parity on 11
        clr_mon();
        send_frame(1'b1, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("t2_perr", pe_cnt, 1);
        check("t2_cv_cnt", cv_cnt, 0);
        check("t2_ferr", fe_cnt, 0);
        check("t2_err", err_count, 4'd1);

        // 3: framing error on 01 followed by a 40-cycle break
        clr_mon();
        bit_tx(1'b0);
        bit_tx(1'b1);
        bit_tx(1'b0);
        bit_tx(1'b0);
        serial_in = 1'b0;
        repeat (CPB + 40) @(negedge clk);
        check("t3_busy_low", rx_busy, 1'b1);
        check("t3_ferr", fe_cnt, 1);
        check("t3_perr", pe_cnt, 0);
        check("t3_cv_cnt", cv_cnt, 0);
        check("t3_err", err_count, 4'd2);
        idle(8);
        check("t3_busy_high", rx_busy, 1'b0);
        check("t3_ferr_once", fe_cnt, 1);
        check("t3_cv_after", cv_cnt, 0);

        // 4: short glitch on idle line
        clr_mon();
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        idle(12);
        check("t4_cv_cnt", cv_cnt, 0);
        check("t4_perr", pe_cnt, 0);
        check("t4_ferr", fe_cnt, 0);
        check("t4_err", err_count, 4'd2);
        check("t4_busy", rx_busy, 1'b0);

        // 5: back-to-back good frames, then saturate the error counter
        clr_mon();
        send_frame(1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1);
        idle(6);
        check("t5_cv_cnt", cv_cnt, 3);
        pop_comm(c);
        check("t5_comm0", c, 2'b01);
        pop_comm(c);
        check("t5_comm1", c, 2'b00);
        pop_comm(c);
        check("t5_comm2", c, 2'b11);
        check("t5_perr", pe_cnt, 0);
        clr_mon();
        for (int i = 0; i < 17; i++) begin
            send_frame(1'b1, 1'b0, 1'b1, 1'b1);
            if (i == 4) begin
                idle(6);
                check("t5_err_mid", err_count, 4'd7);
            end
        end
        idle(6);
        check("t5_err_sat", err_count, 4'd15);
        check("t5_perr_cnt", pe_cnt, 17);
        check("t5_cv_none", cv_cnt, 0);

        // 6: reset during DATA, then a fresh frame
        clr_mon();
        bit_tx(1'b0);
        bit_tx(1'b1);
        serial_in = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("t6_busy_pre", rx_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_valid", comm_valid, 1'b0);
        check("t6_busy", rx_busy, 1'b0);
        check("t6_err", err_count, 4'd0);
        check("t6_comm", receive_comm, 2'b00);
        check("t6_pf", {parity_err, frame_err}, 2'b00);
        check("t6_cv_none", cv_cnt, 0);
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(5);
        clr_mon();
        send_frame(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);
        check("t6_cv_cnt", cv_cnt, 1);
        pop_comm(c);
        check("t6_fresh", c, 2'b01);
        check("t6_err_after", err_count, 4'd0);
        check("t6_perr", pe_cnt, 0);

        check("stray_comm", stray, 0);
        check("pulse_width", wide, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
